// File: rtl/zimo_pkg.sv
// rtl/zimo_pkg.sv - shared glyph widths, loader states and byte-to-bit mapping
package zimo_pkg;

  localparam int ZIMO_W     = 256;
  localparam int ZIMO_BYTES = 32;
  localparam int ZIMO_AMP_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } zimo_state_e;

  // Byte j sits at bits [8j+7:8j]; row r is bytes 2r (left half) and 2r+1 (right half).
  function automatic logic [7:0] zimo_byte_lsb(input logic [4:0] j);
    return {j, 3'b000};
  endfunction

endpackage

// File: rtl/zimo_loader_if.sv
// rtl/zimo_loader_if.sv - request, font ROM and bitmap signals of the glyph loader
interface zimo_loader_if import zimo_pkg::*; #(
  parameter int IDX_W = 8
);

  logic              load_req;
  logic [IDX_W-1:0]  glyph_idx;
  logic              busy;
  logic              rom_en;
  logic [IDX_W+4:0]  rom_addr;
  logic [7:0]        rom_data;
  logic [ZIMO_W-1:0] zimo;
  logic              zimo_valid;

  modport master (
    output load_req, glyph_idx, rom_data,
    input  busy, rom_en, rom_addr, zimo, zimo_valid
  );

  modport slave (
    input  load_req, glyph_idx, rom_data,
    output busy, rom_en, rom_addr, zimo, zimo_valid
  );

endinterface

// File: rtl/zimo_loader.sv
// rtl/zimo_loader.sv - fetches one 32-byte glyph from font ROM into a 256-bit word
module zimo_loader import zimo_pkg::*; #(
  parameter int IDX_W   = 8,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  zimo_loader_if.slave  ldr
);

  zimo_state_e       state_q;
  logic              busy_q;
  logic              rom_en_q;
  logic [IDX_W+4:0]  rom_addr_q;
  logic [ROM_LAT-1:0] en_dly_q;
  logic [4:0]        cap_cnt_q;
  logic [1:0]        drain_cnt_q;
  logic [ZIMO_W-1:0] shadow_q;
  logic [ZIMO_W-1:0] shadow_d;
  logic [ZIMO_W-1:0] zimo_q;
  logic              zimo_valid_q;
  logic              cap;

  // The delayed enable lines up with the byte the ROM returns this cycle.
  assign cap = en_dly_q[ROM_LAT-1];

  always_comb begin
    shadow_d = shadow_q;
    if (cap) begin
      shadow_d[zimo_byte_lsb(cap_cnt_q) +: 8] = ldr.rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      en_dly_q     <= '0;
      cap_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      shadow_q     <= '0;
      zimo_q       <= '0;
      zimo_valid_q <= 1'b0;
    end else begin
      zimo_valid_q <= 1'b0;
      shadow_q     <= shadow_d;
      en_dly_q[0]  <= rom_en_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        en_dly_q[i] <= en_dly_q[i-1];
      end
      if (cap) begin
        cap_cnt_q <= cap_cnt_q + 5'd1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (ldr.load_req) begin
            state_q    <= FETCH;
            busy_q     <= 1'b1;
            rom_en_q   <= 1'b1;
            rom_addr_q <= {ldr.glyph_idx, 5'd0};
            cap_cnt_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        FETCH: begin
          // Only the low five bits count, so the glyph block never carries out.
          if (rom_addr_q[4:0] == 5'd31) begin
            rom_en_q    <= 1'b0;
            drain_cnt_q <= '0;
            state_q     <= DRAIN;
          end else begin
            rom_addr_q[4:0] <= rom_addr_q[4:0] + 5'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 2'(ROM_LAT - 1)) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            zimo_q       <= shadow_d;
            zimo_valid_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ldr.busy       = busy_q;
  assign ldr.rom_en     = rom_en_q;
  assign ldr.rom_addr   = rom_addr_q;
  assign ldr.zimo       = zimo_q;
  assign ldr.zimo_valid = zimo_valid_q;

endmodule

// File: tb/tb_zimo_loader.sv
// tb/tb_zimo_loader.sv - self-checking bench for zimo_loader at ROM_LAT 1 and 3
module tb_zimo_loader;
  import zimo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zimo_loader_if #(.IDX_W(8)) b1();
  zimo_loader_if #(.IDX_W(8)) b3();

  zimo_loader #(.IDX_W(8), .ROM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .ldr(b1.slave));
  zimo_loader #(.IDX_W(8), .ROM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .ldr(b3.slave));

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] rom_byte(input logic [12:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [ZIMO_W-1:0] exp_glyph(input logic [7:0] idx);
    logic [ZIMO_W-1:0] e;
    logic [12:0] a;
    e = '0;
    for (int j = 0; j < 32; j++) begin
      a = 13'(idx) * 13'd32 + 13'(j);
      e[j*8 +: 8] = rom_byte(a);
    end
    return e;
  endfunction

  // Font ROM models; data outside an enabled read is junk.
  logic [7:0] r1_q;
  logic [7:0] r3_q [3];
  always @(posedge clk) begin
    r1_q    <= b1.rom_en ? rom_byte(b1.rom_addr) : 8'h5A;
    r3_q[0] <= b3.rom_en ? rom_byte(b3.rom_addr) : 8'h5A;
    r3_q[1] <= r3_q[0];
    r3_q[2] <= r3_q[1];
  end
  assign b1.rom_data = r1_q;
  assign b3.rom_data = r3_q[2];

  task automatic chk(input string name, input logic [ZIMO_W-1:0] act, input logic [ZIMO_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboards: expected bitmaps queued at request, popped on zimo_valid.
  logic [ZIMO_W-1:0] sb1 [$];
  logic [ZIMO_W-1:0] sb3 [$];
  logic [ZIMO_W-1:0] hold1 = '0;
  logic [ZIMO_W-1:0] e1, e3;

  always @(negedge clk) begin
    if (b1.zimo_valid === 1'b1) begin
      if (sb1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_unexpected_valid: got valid want none");
      end else begin
        e1 = sb1.pop_front();
        chk("sb1_zimo", b1.zimo, e1);
        hold1 = e1;
      end
    end
    if (b3.zimo_valid === 1'b1) begin
      if (sb3.size() == 0) begin
        total++; bad++;
        $display("FAIL sb3_unexpected_valid: got valid want none");
      end else begin
        e3 = sb3.pop_front();
        chk("sb3_zimo", b3.zimo, e3);
      end
    end
  end

  typedef struct {
    logic [7:0]  idx;
    logic [12:0] a_first;
    logic [12:0] a_last;
  } vec_t;

  vec_t vt [6];

  task automatic fetch1(input vec_t v);
    logic [12:0] base, a_first, a_last;
    bit en_ok, addr_ok, busy_ok, hold_ok;
    int lat;
    base = 13'(v.idx) * 13'd32;
    en_ok = 1; addr_ok = 1; busy_ok = 1; hold_ok = 1; lat = -1;
    a_first = 'x; a_last = 'x;
    @(posedge clk); #1;
    chk("idle_busy", 256'(b1.busy), 256'(0));
    b1.load_req  = 1'b1;
    b1.glyph_idx = v.idx;
    sb1.push_back(exp_glyph(v.idx));
    @(posedge clk); #1;
    b1.load_req  = 1'b0;
    b1.glyph_idx = ~v.idx;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1)  a_first = b1.rom_addr;
      if (c == 32) a_last  = b1.rom_addr;
      if (b1.rom_en !== (c <= 32)) en_ok = 0;
      if (c <= 32 && b1.rom_addr !== base + 13'(c - 1)) addr_ok = 0;
      if (b1.busy !== (c <= 33)) busy_ok = 0;
      if (b1.zimo_valid === 1'b1) lat = c;
      else if (b1.zimo !== hold1) hold_ok = 0;
    end
    chk_int($sformatf("lat_g%0d", v.idx), lat, 34);
    chk($sformatf("addr_first_g%0d", v.idx), 256'(a_first), 256'(v.a_first));
    chk($sformatf("addr_last_g%0d", v.idx), 256'(a_last), 256'(v.a_last));
    chk_int($sformatf("addr_seq_g%0d", v.idx), int'(addr_ok), 1);
    chk_int($sformatf("rom_en_g%0d", v.idx), int'(en_ok), 1);
    chk_int($sformatf("busy_g%0d", v.idx), int'(busy_ok), 1);
    chk_int($sformatf("zimo_hold_g%0d", v.idx), int'(hold_ok), 1);
  endtask

  int acc [$];
  int cyc, vcnt, lat3;
  bit tog, busy3_ok;

  initial begin
    vt[0] = '{8'd3,   13'd96,   13'd127};
    vt[1] = '{8'd255, 13'd8160, 13'd8191};
    vt[2] = '{8'd0,   13'd0,    13'd31};
    vt[3] = '{8'd5,   13'd160,  13'd191};
    vt[4] = '{8'd9,   13'd288,  13'd319};
    vt[5] = '{8'd170, 13'd5440, 13'd5471};

    b1.load_req = 1'b0; b1.glyph_idx = '0;
    b3.load_req = 1'b0; b3.glyph_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(b1.busy), 256'(0));
    chk("rst_rom_en", 256'(b1.rom_en), 256'(0));
    chk("rst_rom_addr", 256'(b1.rom_addr), 256'(0));
    chk("rst_zimo", b1.zimo, 256'(0));
    chk("rst_valid", 256'(b1.zimo_valid), 256'(0));
    @(negedge clk) rst_n = 1'b1;

    // Reset in cycle 20 of a fetch: everything clears, no valid pulse.
    @(posedge clk); #1;
    b1.load_req = 1'b1; b1.glyph_idx = 8'd7;
    @(posedge clk); #1;
    b1.load_req = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_busy", 256'(b1.busy), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 256'(b1.busy), 256'(0));
    chk("mid_rst_rom_en", 256'(b1.rom_en), 256'(0));
    chk("mid_rst_rom_addr", 256'(b1.rom_addr), 256'(0));
    chk("mid_rst_zimo", b1.zimo, 256'(0));
    @(negedge clk) rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b1.zimo_valid === 1'b1) vcnt++;
    end
    chk_int("mid_rst_no_valid", vcnt, 0);
    chk("mid_rst_zimo_after", b1.zimo, 256'(0));

    for (int i = 0; i < 6; i++) fetch1(vt[i]);

    // load_req held high, glyph alternating 0/1 after each accept.
    @(posedge clk); #1;
    b1.load_req = 1'b1; b1.glyph_idx = 8'd0;
    cyc = 0; tog = 0;
    while (acc.size() < 4 && cyc < 400) begin
      if (b1.busy === 1'b0) begin
        acc.push_back(cyc);
        sb1.push_back(exp_glyph(b1.glyph_idx));
        tog = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (tog) begin
        b1.glyph_idx = b1.glyph_idx ^ 8'd1;
        tog = 0;
      end
    end
    b1.load_req = 1'b0;
    chk_int("b2b_accepts", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) chk_int($sformatf("b2b_gap%0d", i), acc[i] - acc[i-1], 34);
    for (int k = 0; k < 100 && sb1.size() != 0; k++) @(posedge clk);
    #1;
    chk_int("b2b_drained", sb1.size(), 0);

    // ROM_LAT=3 instance: valid in cycle 36, busy for cycles 1..35.
    @(posedge clk); #1;
    b3.load_req = 1'b1; b3.glyph_idx = 8'd3;
    sb3.push_back(exp_glyph(8'd3));
    @(posedge clk); #1;
    b3.load_req = 1'b0;
    lat3 = -1; busy3_ok = 1;
    for (int c = 1; c <= 60 && lat3 < 0; c++) begin
      @(negedge clk);
      if (b3.busy !== (c <= 35)) busy3_ok = 0;
      if (b3.zimo_valid === 1'b1) lat3 = c;
    end
    chk_int("lat3", lat3, 36);
    chk_int("busy3", int'(busy3_ok), 1);

    repeat (3) @(posedge clk);
    #1;
    chk_int("sb1_empty", sb1.size(), 0);
    chk_int("sb3_empty", sb3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
